// File: rtl/fir_fmt_pkg.sv
// Shared widths, rounding constant and the round/saturate helper for the
// FIR output formatter (sfix33_En31 -> sfix16_En15).
package fir_fmt_pkg;
  localparam int IN_W     = 33;
  localparam int IN_FRAC  = 31;
  localparam int OUT_W    = 16;
  localparam int OUT_FRAC = 15;
  localparam int SHIFT    = IN_FRAC - OUT_FRAC;
  localparam int SUM_W    = IN_W + 1;        // one guard bit for the rounding add
  localparam int R_W      = SUM_W - SHIFT;   // 18-bit shifted result

  localparam logic [SUM_W-1:0] RND_CONST = SUM_W'(1) << (SHIFT - 1);
  localparam logic [OUT_W-1:0] OUT_MAX   = 16'h7FFF;
  localparam logic [OUT_W-1:0] OUT_MIN   = 16'h8000;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
  } fmt_res_t;

  // Round half up (toward +inf), then clamp to the 16-bit signed range.
  function automatic fmt_res_t round_sat(input logic [IN_W-1:0] x);
    logic signed [SUM_W-1:0] sum;
    logic        [R_W-1:0]   r;
    fmt_res_t                res;
    sum = $signed({x[IN_W-1], x}) + $signed(RND_CONST);
    r   = sum[SUM_W-1:SHIFT];
    // Result fits only if every bit above the output sign bit matches it.
    if (!r[R_W-1] && (|r[R_W-2:OUT_W-1])) begin
      res.data = OUT_MAX;
      res.sat  = 1'b1;
    end else if (r[R_W-1] && !(&r[R_W-2:OUT_W-1])) begin
      res.data = OUT_MIN;
      res.sat  = 1'b1;
    end else begin
      res.data = r[OUT_W-1:0];
      res.sat  = 1'b0;
    end
    return res;
  endfunction
endpackage

// File: rtl/fir_sync_fifo.sv
// Pointer-based synchronous FIFO. Head output is combinational from the
// array while non-empty and holds the last popped word while empty.
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_last;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = o_empty ? r_last : r_mem[r_rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers, occupancy and the held head value; DEPTH is a power of two
  // so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fir_output_formatter.sv
// Captures the serial FIR output once per sample period, rounds/saturates
// it to sfix16_En15 and queues it behind a valid/ready interface.
module fir_output_formatter
  import fir_fmt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PHASES     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic [IN_W-1:0]  sample_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      sat_count,
  output logic             overflow,
  input  logic             clear_flags
);
  localparam int CW = (PHASES > 1) ? $clog2(PHASES) : 1;

  logic [CW-1:0]   r_cnt;
  logic [IN_W-1:0] r_cap;
  logic            r_cap_vld;
  logic            w_capture, w_push, w_pop, w_wr, w_drop;
  logic            w_full, w_empty;
  fmt_res_t        w_res;

  assign w_capture = (r_cnt == '0) & clk_enable;
  assign w_res     = round_sat(r_cap);
  assign w_push    = r_cap_vld & clk_enable;
  assign w_pop     = out_valid & out_ready & clk_enable;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;
  assign out_valid = ~w_empty;

  // Phase counter mirroring the filter's, starting at PHASES-1 so the
  // first enabled edge lands on phase 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_cnt <= CW'(PHASES - 1);
    else if (clk_enable) r_cnt <= (r_cnt == CW'(PHASES - 1)) ? '0 : r_cnt + 1'b1;
  end

  // Capture stage: one-cycle valid pulse per sample period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap     <= '0;
      r_cap_vld <= 1'b0;
    end else if (w_capture) begin
      r_cap     <= sample_in;
      r_cap_vld <= 1'b1;
    end else if (clk_enable) begin
      r_cap_vld <= 1'b0;
    end
  end

  // Sticky status: saturation counter and overflow; clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= '0;
      overflow  <= 1'b0;
    end else if (clk_enable) begin
      if (clear_flags) begin
        sat_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (w_push && w_res.sat && (sat_count != 16'hFFFF))
          sat_count <= sat_count + 1'b1;
        if (w_drop) overflow <= 1'b1;
      end
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_wr),
    .i_pop   (w_pop),
    .i_data  (w_res.data),
    .o_head  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_fir_output_formatter.sv
// Randomized and directed bench for fir_output_formatter against a
// queue-based behavioural model.
module tb_fir_output_formatter;
  localparam int DEPTH = 4;
  localparam int PH    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b0;
  logic [32:0] sample_in = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sat_count;
  logic        overflow;
  logic        clear_flags = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int          m_phase;
  bit          m_pend;
  logic [32:0] m_cap;
  logic [15:0] m_q[$];
  logic [15:0] m_last;
  int          m_sat;
  bit          m_ovf;

  logic [32:0] corner [8];

  fir_output_formatter #(.FIFO_DEPTH(DEPTH), .PHASES(PH)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .sample_in   (sample_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sat_count   (sat_count),
    .overflow    (overflow),
    .clear_flags (clear_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Real-valued rule: value = x/2^31, out = floor(value*2^15 + 0.5), clamped.
  function automatic logic [16:0] fmt(input logic [32:0] x);
    longint v, num, q;
    v = longint'({31'b0, x});
    if (x[32]) v = v - 64'sh2_0000_0000;
    num = v + 32768;
    q = num / 65536;
    if (num < 0 && (num % 65536) != 0) q = q - 1;
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  task automatic model_reset();
    m_phase = PH - 1;
    m_pend  = 0;
    m_cap   = '0;
    m_q.delete();
    m_last  = '0;
    m_sat   = 0;
    m_ovf   = 0;
  endtask

  task automatic model_advance(input logic [32:0] s, input logic rdy, input logic en, input logic clr);
    bit full, pop, drop;
    logic [16:0] f;
    if (!en) return;
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() != 0) && rdy;
    drop = 0;
    f    = fmt(m_cap);
    if (pop) m_last = m_q.pop_front();
    if (m_pend) begin
      if (!full || pop) m_q.push_back(f[15:0]);
      else drop = 1;
    end
    if (clr) begin
      m_sat = 0;
      m_ovf = 0;
    end else begin
      if (m_pend && f[16] && m_sat < 65535) m_sat++;
      if (drop) m_ovf = 1;
    end
    m_pend = (m_phase == 0);
    if (m_phase == 0) m_cap = s;
    m_phase = (m_phase + 1) % PH;
  endtask

  task automatic check_outputs();
    chk("valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    chk("data", {16'b0, out_data}, {16'b0, (m_q.size() != 0) ? m_q[0] : m_last});
    chk("sat_count", {16'b0, sat_count}, m_sat);
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  // Called just after a falling edge: check, drive, advance model, next cycle.
  task automatic step(input logic [32:0] s, input logic rdy, input logic en, input logic clr);
    check_outputs();
    sample_in   = s;
    out_ready   = rdy;
    clk_enable  = en;
    clear_flags = clr;
    model_advance(s, rdy, en, clr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", {16'b0, out_data}, 32'd0);
    chk("rst_sat", {16'b0, sat_count}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic align();
    for (int i = 0; i < PH && m_phase != 0; i++) step('0, 1'b1, 1'b1, 1'b0);
  endtask

  // Capture v at phase 0, then check the formatted value two cycles later.
  task automatic one_vec(input string tag, input logic [32:0] v, input logic [15:0] exp);
    align();
    step(v, 1'b1, 1'b1, 1'b0);
    step(v, 1'b1, 1'b1, 1'b0);
    chk(tag, {16'b0, out_data}, {16'b0, exp});
    step(v, 1'b1, 1'b1, 1'b0);
    step(v, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    logic [32:0] s;
    corner[0] = 33'h0_4000_0000; corner[1] = 33'h0_0000_8000;
    corner[2] = 33'h0_0000_7FFF; corner[3] = 33'h1_FFFF_8000;
    corner[4] = 33'h0_8000_0000; corner[5] = 33'h1_0000_0000;
    corner[6] = 33'h0_7FFF_7FFF; corner[7] = 33'h1_FFFF_7FFF;
    model_reset();
    @(negedge clk);
    do_reset();

    // rounding exactness
    one_vec("rnd_half", 33'h0_4000_0000, 16'h4000);
    one_vec("rnd_up", 33'h0_0000_8000, 16'h0001);
    one_vec("rnd_dn", 33'h0_0000_7FFF, 16'h0000);
    one_vec("rnd_neg", 33'h1_FFFF_8000, 16'h0000);
    chk("rnd_nosat", {16'b0, sat_count}, 32'd0);

    // saturation and clear
    one_vec("sat_pos", 33'h0_8000_0000, 16'h7FFF);
    one_vec("sat_neg", 33'h1_0000_0000, 16'h8000);
    chk("sat_two", {16'b0, sat_count}, 32'd2);
    step('0, 1'b1, 1'b1, 1'b1);
    chk("sat_clr", {16'b0, sat_count}, 32'd0);

    // backpressure: 5 periods, 4 stored, 5th dropped
    for (int i = 0; i < 4; i++) step('0, 1'b1, 1'b1, 1'b0);
    align();
    for (int p = 0; p < 5; p++)
      for (int c = 0; c < PH; c++)
        step(33'((p + 1) << 24), 1'b0, 1'b1, 1'b0);
    chk("bp_ovf", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_order", {16'b0, out_data}, 32'((i + 1) * 256));
      step(33'h0_0100_0000, 1'b1, 1'b1, 1'b0);
    end
    step('0, 1'b1, 1'b1, 1'b1);

    // simultaneous push/pop while full
    for (int i = 0; i < 40; i++)
      step(33'($urandom()), (m_pend && m_q.size() == DEPTH), 1'b1, 1'b0);
    chk("pp_ovf", {31'b0, overflow}, 32'd0);
    chk("pp_full", {31'b0, out_valid}, 32'd1);

    // clock-enable gating
    for (int i = 0; i < 10; i++) step(33'($urandom()), 1'b1, 1'b0, 1'b1);

    // reset with 3 entries queued
    for (int i = 0; i < 40 && m_q.size() < 3; i++) step(33'($urandom()), 1'b0, 1'b1, 1'b0);
    chk("q3", {31'b0, out_valid}, 32'd1);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) s = corner[$urandom_range(0, 7)];
      else s = {1'($urandom_range(0, 1)), 32'($urandom())};
      step(s, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 49) == 0));
    end
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_output_formatter.md
# fir_output_formatter

Downstream stage of the 8-tap partly-serial FIR filter (4 phases per sample).
- Captures the filter's sfix33_En31 output once per sample period.
- Rounds and saturates it to sfix16_En15.
- Buffers results in a small FIFO behind a valid/ready interface for the consumer (DAC/stream sink).
- Keeps its own phase counter, identical to the filter's, so capture lands on the first cycle after the filter's output register updates.

## Interface
- FIFO_DEPTH, 4: formatter FIFO entries; power of two, ≥2.
- PHASES, 4: clock cycles per input sample; must equal the filter's serial phase count.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset; one clock, async active-high reset (fixed).
- clk_enable  input  1  global advance enable; same signal that drives the filter.
- sample_in  input  33  filter_out, sfix33_En31.
- out_data  output  16  formatted sample, sfix16_En15; reset 0x0000.
- out_valid  output  1  FIFO non-empty; reset 0.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready & clk_enable.
- sat_count  output  16  number of saturated samples, sticks at 0xFFFF; reset 0.
- overflow  output  1  sticky: a sample was dropped because the FIFO was full; reset 0.
- clear_flags  input  1  synchronous; zeroes sat_count and overflow on the next enabled edge.

## Operation
**Phase counter**
- Width log2(PHASES). Reset value PHASES-1.
- On each enabled edge, increments and wraps to 0 after PHASES-1.
- capture = (count==0) & clk_enable; this is the first cycle the filter's new output is visible.

**Stage 1**
- On capture, sample_in is registered into cap_reg and cap_vld is set.
- cap_vld clears on the next enabled edge.

**Stage 2: round and saturate (combinational on cap_reg)**
- Compute a 34-bit sign-extended sum: cap_reg + 2^15. This is round-half-up, toward +inf.
- Arithmetic-shift the sum right by 16, giving a 18-bit result r.
- If r > 32767, output 0x7FFF. If r < -32768, output 0x8000. Otherwise output r[15:0].
- sat_hit is asserted when either clamp applies.

**FIFO push/pop**
- push = cap_vld & clk_enable.
- pop = out_valid & out_ready & clk_enable.
- If the FIFO is full and no pop occurs in the same cycle, the new sample is discarded and overflow is set.
- Push and pop in the same cycle while full: both succeed; the occupancy count is unchanged.
- Pop while empty: impossible, because out_valid is 0.

**Flags**
- sat_count increments on each accepted or dropped sample with sat_hit; it saturates at 0xFFFF.
- clear_flags takes priority over a simultaneous increment or overflow set.

**Data output**
- out_data always shows the FIFO head. It holds its value while out_valid=0.

**Clock enable**
- With clk_enable low, all state holds (counter, pipeline, FIFO, flags).

**Reset**
- Reset mid-operation empties the FIFO, clears cap_vld and the flags, and returns the counter to PHASES-1.
- Any in-flight sample is lost.

## Timing
- Capture at enabled cycle T (count==0). cap_reg is valid in T+1.
- The FIFO write occurs at the end of T+1.
- out_valid rises in T+2 when the FIFO was empty: 2-cycle latency from capture.
- Steady state: one push per PHASES enabled cycles.
- An always-ready consumer never lets occupancy exceed 1.
- FIFO ready-to-valid is registered; there is no combinational path from out_ready to out_valid.
- After reset with the filter also reset: the first capture occurs on the first enabled cycle (count wraps 3→0) and captures the filter's reset value 0.

## Structure
- Shared package fir_fmt_pkg holds:
  - width constants: IN_W=33, IN_FRAC=31, OUT_W=16, OUT_FRAC=15, SHIFT=IN_FRAC-OUT_FRAC;
  - the rounding constant 2^(SHIFT-1);
  - saturation constants OUT_MAX=16'h7FFF and OUT_MIN=16'h8000.
- Sub-module fir_sync_fifo, parameterised by WIDTH and DEPTH:
  - pointer-based, with count/full/empty;
  - async active-high reset;
  - push/pop inputs, head-data output.
- The counter, capture register, rounder and flags live in the top module.

## Test plan
- Rounding exactness:
  - 0x0_4000_0000 (0.5) → 0x4000.
  - 0x0_0000_8000 → 0x0001.
  - 0x0_0000_7FFF → 0x0000.
  - 0x1_FFFF_8000 → 0x0000.
  - sat_count stays 0.
- Saturation:
  - 0x0_8000_0000 (+1.0) → 0x7FFF.
  - 0x1_0000_0000 (-2.0) → 0x8000.
  - sat_count = 2.
  - clear_flags → 0.
- Latency and cadence, out_ready=1, clk_enable=1:
  - a new sample value appears on out_valid exactly 2 cycles after each count==0 cycle;
  - pulses occur every 4 cycles.
- Backpressure: out_ready=0 for 5 sample periods with 5 distinct values.
  - 4 are stored, the 5th is dropped, overflow=1.
  - Raising out_ready drains the 4 in order.
- Simultaneous push/pop at full: out_ready pulsed in a push cycle while full → no drop, overflow stays 0.
- Reset mid-operation:
  - assert reset with 3 entries queued → out_valid=0, out_data=0x0000, flags 0 immediately.
  - Enable/clk_enable gating: holding clk_enable low for 10 cycles freezes count and out_valid.
